// File: rtl/cabac_bin_decoder.sv
// H.265 CABAC context-coded bin decoder: LPS/MPS decision, context update and renormalisation in one step.
// Optional CABAC_DEC_BIN_OUT_REG_EN registers all outputs for a single cycle of latency.
module cabac_bin_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] i_ivlCurrRange,
    input  logic [8:0] i_ivlOffset,
    input  logic [5:0] i_pStateIdx,
    input  logic       i_valMps,
    input  logic [5:0] i_rbsp_in,
    output logic [8:0] o_ivlCurrRange,
    output logic [8:0] o_ivlOffset,
    output logic [5:0] o_pStateIdx,
    output logic       o_valMps,
    output logic       o_binVal,
    output logic [2:0] o_output_len
);

    function automatic logic [31:0] lps_row(input logic [5:0] s);
        logic [31:0] row;
        case (s)
            6'd0:  row = {8'd128, 8'd176, 8'd208, 8'd240};
            6'd1:  row = {8'd128, 8'd167, 8'd197, 8'd227};
            6'd2:  row = {8'd128, 8'd158, 8'd187, 8'd216};
            6'd3:  row = {8'd123, 8'd150, 8'd178, 8'd205};
            6'd4:  row = {8'd116, 8'd142, 8'd169, 8'd195};
            6'd5:  row = {8'd111, 8'd135, 8'd160, 8'd185};
            6'd6:  row = {8'd105, 8'd128, 8'd152, 8'd175};
            6'd7:  row = {8'd100, 8'd122, 8'd144, 8'd166};
            6'd8:  row = {8'd95,  8'd116, 8'd137, 8'd158};
            6'd9:  row = {8'd90,  8'd110, 8'd130, 8'd150};
            6'd10: row = {8'd85,  8'd104, 8'd123, 8'd142};
            6'd11: row = {8'd81,  8'd99,  8'd117, 8'd135};
            6'd12: row = {8'd77,  8'd94,  8'd111, 8'd128};
            6'd13: row = {8'd73,  8'd89,  8'd105, 8'd122};
            6'd14: row = {8'd69,  8'd85,  8'd100, 8'd116};
            6'd15: row = {8'd66,  8'd80,  8'd95,  8'd110};
            6'd16: row = {8'd62,  8'd76,  8'd90,  8'd104};
            6'd17: row = {8'd59,  8'd72,  8'd86,  8'd99};
            6'd18: row = {8'd56,  8'd69,  8'd81,  8'd94};
            6'd19: row = {8'd53,  8'd65,  8'd77,  8'd89};
            6'd20: row = {8'd51,  8'd62,  8'd73,  8'd85};
            6'd21: row = {8'd48,  8'd59,  8'd69,  8'd80};
            6'd22: row = {8'd46,  8'd56,  8'd66,  8'd76};
            6'd23: row = {8'd43,  8'd53,  8'd63,  8'd72};
            6'd24: row = {8'd41,  8'd50,  8'd59,  8'd69};
            6'd25: row = {8'd39,  8'd48,  8'd56,  8'd65};
            6'd26: row = {8'd37,  8'd45,  8'd54,  8'd62};
            6'd27: row = {8'd35,  8'd43,  8'd51,  8'd59};
            6'd28: row = {8'd33,  8'd41,  8'd48,  8'd56};
            6'd29: row = {8'd32,  8'd39,  8'd46,  8'd53};
            6'd30: row = {8'd30,  8'd37,  8'd43,  8'd50};
            6'd31: row = {8'd29,  8'd35,  8'd41,  8'd48};
            6'd32: row = {8'd27,  8'd33,  8'd39,  8'd45};
            6'd33: row = {8'd26,  8'd31,  8'd37,  8'd43};
            6'd34: row = {8'd24,  8'd30,  8'd35,  8'd41};
            6'd35: row = {8'd23,  8'd28,  8'd33,  8'd39};
            6'd36: row = {8'd22,  8'd27,  8'd32,  8'd37};
            6'd37: row = {8'd21,  8'd26,  8'd30,  8'd35};
            6'd38: row = {8'd20,  8'd24,  8'd29,  8'd33};
            6'd39: row = {8'd19,  8'd23,  8'd27,  8'd31};
            6'd40: row = {8'd18,  8'd22,  8'd26,  8'd30};
            6'd41: row = {8'd17,  8'd21,  8'd25,  8'd28};
            6'd42: row = {8'd16,  8'd20,  8'd23,  8'd27};
            6'd43: row = {8'd15,  8'd19,  8'd22,  8'd25};
            6'd44: row = {8'd14,  8'd18,  8'd21,  8'd24};
            6'd45: row = {8'd14,  8'd17,  8'd20,  8'd23};
            6'd46: row = {8'd13,  8'd16,  8'd19,  8'd22};
            6'd47: row = {8'd12,  8'd15,  8'd18,  8'd21};
            6'd48: row = {8'd12,  8'd14,  8'd17,  8'd20};
            6'd49: row = {8'd11,  8'd14,  8'd16,  8'd19};
            6'd50: row = {8'd11,  8'd13,  8'd15,  8'd18};
            6'd51: row = {8'd10,  8'd12,  8'd15,  8'd17};
            6'd52: row = {8'd10,  8'd12,  8'd14,  8'd16};
            6'd53: row = {8'd9,   8'd11,  8'd13,  8'd15};
            6'd54: row = {8'd9,   8'd11,  8'd12,  8'd14};
            6'd55: row = {8'd8,   8'd10,  8'd12,  8'd14};
            6'd56: row = {8'd8,   8'd9,   8'd11,  8'd13};
            6'd57: row = {8'd7,   8'd9,   8'd11,  8'd12};
            6'd58: row = {8'd7,   8'd9,   8'd10,  8'd12};
            6'd59: row = {8'd7,   8'd8,   8'd10,  8'd11};
            6'd60: row = {8'd6,   8'd8,   8'd9,   8'd11};
            6'd61: row = {8'd6,   8'd7,   8'd9,   8'd10};
            6'd62: row = {8'd6,   8'd7,   8'd8,   8'd9};
            default: row = {8'd2,  8'd2,   8'd2,   8'd2};
        endcase
        return row;
    endfunction

    function automatic logic [5:0] trans_lps(input logic [5:0] s);
        logic [5:0] t;
        case (s)
            6'd0, 6'd1:                      t = 6'd0;
            6'd2:                            t = 6'd1;
            6'd3, 6'd4:                      t = 6'd2;
            6'd5, 6'd6:                      t = 6'd4;
            6'd7:                            t = 6'd5;
            6'd8:                            t = 6'd6;
            6'd9:                            t = 6'd7;
            6'd10:                           t = 6'd8;
            6'd11, 6'd12:                    t = 6'd9;
            6'd13, 6'd14:                    t = 6'd11;
            6'd15:                           t = 6'd12;
            6'd16, 6'd17:                    t = 6'd13;
            6'd18, 6'd19:                    t = 6'd15;
            6'd20, 6'd21:                    t = 6'd16;
            6'd22, 6'd23:                    t = 6'd18;
            6'd24, 6'd25:                    t = 6'd19;
            6'd26, 6'd27:                    t = 6'd21;
            6'd28, 6'd29:                    t = 6'd22;
            6'd30:                           t = 6'd23;
            6'd31, 6'd32:                    t = 6'd24;
            6'd33:                           t = 6'd25;
            6'd34, 6'd35:                    t = 6'd26;
            6'd36, 6'd37:                    t = 6'd27;
            6'd38:                           t = 6'd28;
            6'd39, 6'd40:                    t = 6'd29;
            6'd41, 6'd42, 6'd43:             t = 6'd30;
            6'd44:                           t = 6'd31;
            6'd45, 6'd46:                    t = 6'd32;
            6'd47, 6'd48, 6'd49:             t = 6'd33;
            6'd50, 6'd51:                    t = 6'd34;
            6'd52, 6'd53, 6'd54:             t = 6'd35;
            6'd55, 6'd56, 6'd57:             t = 6'd36;
            6'd58, 6'd59, 6'd60:             t = 6'd37;
            6'd61, 6'd62:                    t = 6'd38;
            default:                         t = 6'd63;
        endcase
        return t;
    endfunction

    logic [31:0] row;
    logic [8:0]  lps, r_mps, rng, off;
    logic        is_lps;
    logic [2:0]  n;
    logic [14:0] off_ext;
    logic [8:0]  c_range, c_offset;
    logic [5:0]  c_pst;
    logic        c_mps, c_bin;

    always_comb begin
        row = lps_row(i_pStateIdx);
        case (i_ivlCurrRange[7:6])
            2'd0:    lps = {1'b0, row[31:24]};
            2'd1:    lps = {1'b0, row[23:16]};
            2'd2:    lps = {1'b0, row[15:8]};
            default: lps = {1'b0, row[7:0]};
        endcase
        r_mps  = i_ivlCurrRange - lps;
        is_lps = (i_ivlOffset >= r_mps);
        if (is_lps) begin
            c_bin = ~i_valMps;
            off   = i_ivlOffset - r_mps;
            rng   = lps;
            c_mps = (i_pStateIdx == 6'd0) ? ~i_valMps : i_valMps;
            c_pst = trans_lps(i_pStateIdx);
        end else begin
            c_bin = i_valMps;
            off   = i_ivlOffset;
            rng   = r_mps;
            c_mps = i_valMps;
            c_pst = (i_pStateIdx >= 6'd62) ? i_pStateIdx : i_pStateIdx + 6'd1;
        end
        // Leading-zero count of the 9-bit range gives the renormalisation shift.
        casez (rng)
            9'b1????????: n = 3'd0;
            9'b01???????: n = 3'd1;
            9'b001??????: n = 3'd2;
            9'b0001?????: n = 3'd3;
            9'b00001????: n = 3'd4;
            9'b000001???: n = 3'd5;
            9'b0000001??: n = 3'd6;
            default:      n = 3'd7;
        endcase
        c_range  = rng << n;
        // Bitstream bits follow the offset so a single shift pulls them in MSB-first.
        off_ext  = {off, i_rbsp_in} << n;
        c_offset = off_ext[14:6];
    end

`ifdef CABAC_DEC_BIN_OUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ivlCurrRange <= 9'd510;
            o_ivlOffset    <= 9'd0;
            o_pStateIdx    <= 6'd0;
            o_valMps       <= 1'b0;
            o_binVal       <= 1'b0;
            o_output_len   <= 3'd0;
        end else begin
            o_ivlCurrRange <= c_range;
            o_ivlOffset    <= c_offset;
            o_pStateIdx    <= c_pst;
            o_valMps       <= c_mps;
            o_binVal       <= c_bin;
            o_output_len   <= n;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign o_ivlCurrRange = c_range;
    assign o_ivlOffset    = c_offset;
    assign o_pStateIdx    = c_pst;
    assign o_valMps       = c_mps;
    assign o_binVal       = c_bin;
    assign o_output_len   = n;
`endif

endmodule

// File: tb/tb_cabac_bin_decoder.sv
// Directed and reference-model checks for cabac_bin_decoder, combinational or registered build.
module tb_cabac_bin_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [8:0] i_range = 9'd510;
    logic [8:0] i_off = 9'd0;
    logic [5:0] i_pst = 6'd0;
    logic       i_mps = 1'b0;
    logic [5:0] i_rbsp = 6'd0;
    logic [8:0] o_range, o_off;
    logic [5:0] o_pst;
    logic       o_mps, o_bin;
    logic [2:0] o_len;

    int n_checks = 0;
    int n_fail = 0;

    // Packed view {bin, range, offset, pst, mps, len}.
    logic [28:0] obs;
    assign obs = {o_bin, o_range, o_off, o_pst, o_mps, o_len};

    cabac_bin_decoder dut (
        .clk(clk), .rst(rst),
        .i_ivlCurrRange(i_range), .i_ivlOffset(i_off), .i_pStateIdx(i_pst),
        .i_valMps(i_mps), .i_rbsp_in(i_rbsp),
        .o_ivlCurrRange(o_range), .o_ivlOffset(o_off), .o_pStateIdx(o_pst),
        .o_valMps(o_mps), .o_binVal(o_bin), .o_output_len(o_len)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lps_tab [64][4] = '{
        '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216}, '{123,150,178,205},
        '{116,142,169,195}, '{111,135,160,185}, '{105,128,152,175}, '{100,122,144,166},
        '{95,116,137,158},  '{90,110,130,150},  '{85,104,123,142},  '{81,99,117,135},
        '{77,94,111,128},   '{73,89,105,122},   '{69,85,100,116},   '{66,80,95,110},
        '{62,76,90,104},    '{59,72,86,99},     '{56,69,81,94},     '{53,65,77,89},
        '{51,62,73,85},     '{48,59,69,80},     '{46,56,66,76},     '{43,53,63,72},
        '{41,50,59,69},     '{39,48,56,65},     '{37,45,54,62},     '{35,43,51,59},
        '{33,41,48,56},     '{32,39,46,53},     '{30,37,43,50},     '{29,35,41,48},
        '{27,33,39,45},     '{26,31,37,43},     '{24,30,35,41},     '{23,28,33,39},
        '{22,27,32,37},     '{21,26,30,35},     '{20,24,29,33},     '{19,23,27,31},
        '{18,22,26,30},     '{17,21,25,28},     '{16,20,23,27},     '{15,19,22,25},
        '{14,18,21,24},     '{14,17,20,23},     '{13,16,19,22},     '{12,15,18,21},
        '{12,14,17,20},     '{11,14,16,19},     '{11,13,15,18},     '{10,12,15,17},
        '{10,12,14,16},     '{9,11,13,15},      '{9,11,12,14},      '{8,10,12,14},
        '{8,9,11,13},       '{7,9,11,12},       '{7,9,10,12},       '{7,8,10,11},
        '{6,8,9,11},        '{6,7,9,10},        '{6,7,8,9},         '{2,2,2,2}
    };
    int trans_tab [64] = '{
        0,0,1,2,2,4,4,5,6,7, 8,9,9,11,11,12,13,13,15,15,
        16,16,18,18,19,19,21,21,22,22, 23,24,24,25,26,26,27,27,28,29,
        29,30,30,30,31,32,32,33,33,33, 34,34,35,35,35,36,36,36,37,37,
        37,38,38,63
    };

    // Bit-serial reference engine, one renormalisation step per loop iteration.
    function automatic logic [28:0] model(input int rg, input int of, input int ps,
                                          input int mp, input logic [5:0] bits);
        int lps, r, g, o, bin, nps, nmp, n;
        lps = lps_tab[ps][(rg >> 6) & 3];
        r = rg - lps;
        if (of >= r) begin
            bin = 1 - mp; o = of - r; g = lps;
            nmp = (ps == 0) ? 1 - mp : mp;
            nps = trans_tab[ps];
        end else begin
            bin = mp; o = of; g = r; nmp = mp;
            nps = (ps >= 62) ? ps : ps + 1;
        end
        n = 0;
        while (g < 256) begin
            g = g * 2;
            o = ((o * 2) | ((n < 6) ? int'(bits[5-n]) : 0)) & 511;
            n++;
        end
        return {bin[0], g[8:0], o[8:0], nps[5:0], nmp[0], n[2:0]};
    endfunction

    task automatic drive(input logic [8:0] rg, input logic [8:0] of, input logic [5:0] ps,
                         input logic mp, input logic [5:0] bits);
        i_range = rg; i_off = of; i_pst = ps; i_mps = mp; i_rbsp = bits;
`ifdef CABAC_DEC_BIN_OUT_REG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic test_reset;
        logic [28:0] exp_v;
`ifdef CABAC_DEC_BIN_OUT_REG_EN
        rst = 1'b1;
        #1;
        exp_v = {1'b0, 9'd510, 9'd0, 6'd0, 1'b0, 3'd0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        @(posedge clk); #1;
        rst = 1'b0;
`else
        rst = 1'b1;
        drive(9'd510, 9'd0, 6'd0, 1'b0, 6'd0);
        exp_v = {1'b0, 9'd270, 9'd0, 6'd1, 1'b0, 3'd0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL reset_ignored: got %h expected %h", obs, exp_v);
        end
        rst = 1'b0;
`endif
    endtask

    task automatic test_directed;
        logic [28:0] exp_v;
        drive(9'd510, 9'd0, 6'd0, 1'b0, 6'b000000);
        exp_v = {1'b1 ^ 1'b1, 9'd270, 9'd0, 6'd1, 1'b0, 3'd0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mps_no_renorm: got %h expected %h", obs, exp_v); end

        drive(9'd510, 9'd300, 6'd0, 1'b0, 6'b101010);
        exp_v = {1'b1, 9'd480, 9'd61, 6'd0, 1'b1, 3'd1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lps_pst0: got %h expected %h", obs, exp_v); end

        drive(9'd256, 9'd255, 6'd62, 1'b0, 6'b111111);
        exp_v = {1'b1, 9'd384, 9'd383, 6'd38, 1'b0, 3'd6};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL max_renorm: got %h expected %h", obs, exp_v); end

        drive(9'd256, 9'd0, 6'd0, 1'b1, 6'b100000);
        exp_v = {1'b1, 9'd256, 9'd1, 6'd1, 1'b1, 3'd1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mps_renorm: got %h expected %h", obs, exp_v); end

        drive(9'd320, 9'd250, 6'd10, 1'b1, 6'b110000);
        exp_v = {1'b0, 9'd416, 9'd139, 6'd8, 1'b1, 3'd2};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL lps_q1: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_saturation;
        logic [28:0] exp_v;
        drive(9'd510, 9'd0, 6'd62, 1'b1, 6'b000000);
        exp_v = {1'b1, 9'd501, 9'd0, 6'd62, 1'b1, 3'd0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mps_sat62: got %h expected %h", obs, exp_v); end

        drive(9'd510, 9'd0, 6'd63, 1'b0, 6'b000000);
        exp_v = {1'b0, 9'd508, 9'd0, 6'd63, 1'b0, 3'd0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL mps_sat63: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_random;
        logic [28:0] exp_v;
        int rg, of, ps, mp;
        logic [5:0] bits;
        for (int k = 0; k < 200; k++) begin
            rg = $urandom_range(510, 256);
            of = $urandom_range(rg - 1, 0);
            ps = $urandom_range(62, 0);
            mp = $urandom_range(1, 0);
            bits = 6'($urandom_range(63, 0));
            exp_v = model(rg, of, ps, mp, bits);
            drive(rg[8:0], of[8:0], ps[5:0], mp[0], bits);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random_%0d: in r=%0d o=%0d p=%0d m=%0d b=%b got %h expected %h",
                         k, rg, of, ps, mp, bits, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [28:0] exp_v;
        for (int k = 0; k < 4; k++) begin
            drive(9'd510, 9'd300, 6'd0, 1'b0, 6'b101010);
            exp_v = {1'b1, 9'd480, 9'd61, 6'd0, 1'b1, 3'd1};
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_lps_%0d: got %h expected %h", k, obs, exp_v); end
            drive(9'd510, 9'd0, 6'd0, 1'b0, 6'b000000);
            exp_v = {1'b0, 9'd270, 9'd0, 6'd1, 1'b0, 3'd0};
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_mps_%0d: got %h expected %h", k, obs, exp_v); end
        end
    endtask

`ifdef CABAC_DEC_BIN_OUT_REG_EN
    task automatic test_reset_mid;
        logic [28:0] exp_v;
        drive(9'd256, 9'd0, 6'd0, 1'b1, 6'b100000);
        i_range = 9'd510; i_off = 9'd300; i_pst = 6'd0; i_mps = 1'b0; i_rbsp = 6'b101010;
        #2;
        rst = 1'b1;
        #1;
        exp_v = {1'b0, 9'd510, 9'd0, 6'd0, 1'b0, 3'd0};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_async: got %h expected %h", obs, exp_v); end
        @(posedge clk); #1;
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_hold: got %h expected %h", obs, exp_v); end
        rst = 1'b0;
        drive(9'd510, 9'd300, 6'd0, 1'b0, 6'b101010);
        exp_v = {1'b1, 9'd480, 9'd61, 6'd0, 1'b1, 3'd1};
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_mid_resume: got %h expected %h", obs, exp_v); end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_saturation;
        test_random;
        test_back_to_back;
`ifdef CABAC_DEC_BIN_OUT_REG_EN
        test_reset_mid;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
